result_writeback_mux: RTL and testbench

Parametrised successor to the two-input ALU/shifter output mux. Selects one of NUM_SRC functional-unit results (ALU, shifter, multiplier, load, ...) onto the datapath writeback bus through a registered output stage with a valid/ready handshake. Supports two selection modes: explicit select, which matches the legacy output_cont behaviour, and round-robin arbitration. Sits between the execution units and the register-file write port.

---
 rtl/result_writeback_mux.sv | 130 +++++++++++++
 tb/tb_result_writeback_mux.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_writeback_mux.sv
// Writeback result mux: picks one of NUM_SRC functional-unit results, either by
// explicit select or by round-robin arbitration, into a registered valid/ready
// output stage feeding the register-file write port.
module result_writeback_mux #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC*WIDTH-1:0]   src_data,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic                       arb_mode,
  input  logic [SEL_W-1:0]           sel,
  output logic [WIDTH-1:0]           out_data,
  output logic [SEL_W-1:0]           out_src,
  output logic                       out_zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SEL_W-1:0] RR_INIT = SEL_W'(NUM_SRC - 1);

  logic                 load_c;
  logic                 grant_vld_c;
  logic [SEL_W-1:0]     grant_idx_c;
  logic [NUM_SRC-1:0]   grant_c;
  logic [WIDTH-1:0]     grant_data_c;
  logic                 hi_vld_c;
  logic                 lo_vld_c;
  logic [SEL_W-1:0]     hi_idx_c;
  logic [SEL_W-1:0]     lo_idx_c;
  logic [SEL_W-1:0]     rr_ptr;

  // Output register can take a new word when empty or being drained this cycle
  always_comb begin
    load_c = !out_valid || out_ready;
  end

  // Grant decision. Round-robin splits the sources into those above rr_ptr
  // (searched first) and those at or below it (wrap-around), lowest index first.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    hi_vld_c    = 1'b0;
    lo_vld_c    = 1'b0;
    hi_idx_c    = '0;
    lo_idx_c    = '0;
    if (!arb_mode) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (sel == SEL_W'(i) && src_valid[i]) begin
          grant_vld_c = 1'b1;
          grant_idx_c = SEL_W'(i);
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && SEL_W'(i) > rr_ptr && !hi_vld_c) begin
          hi_vld_c = 1'b1;
          hi_idx_c = SEL_W'(i);
        end
        if (src_valid[i] && SEL_W'(i) <= rr_ptr && !lo_vld_c) begin
          lo_vld_c = 1'b1;
          lo_idx_c = SEL_W'(i);
        end
      end
      grant_vld_c = hi_vld_c || lo_vld_c;
      grant_idx_c = hi_vld_c ? hi_idx_c : lo_idx_c;
    end
  end

  // One-hot grant vector and granted data
  always_comb begin
    grant_c      = '0;
    grant_data_c = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_vld_c && grant_idx_c == SEL_W'(i)) begin
        grant_c[i]   = 1'b1;
        grant_data_c = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Accept only the granted source, and only when the output stage can load
  always_comb begin
    src_ready = load_c ? grant_c : '0;
  end

  // Output stage: load on transfer, drain to empty when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_src   <= '0;
      out_zero  <= 1'b1;
      out_valid <= 1'b0;
    end else if (load_c) begin
      if (grant_vld_c) begin
        out_data  <= grant_data_c;
        out_src   <= grant_idx_c;
        out_zero  <= (grant_data_c == '0);
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer follows round-robin transfers only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= RR_INIT;
    end else if (load_c && grant_vld_c && arb_mode) begin
      rr_ptr <= grant_idx_c;
    end
  end

  // Saturating count of back-pressured cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_result_writeback_mux.sv
// Self-checking bench for result_writeback_mux: directed scenarios plus random
// traffic, checked every cycle against a behavioural model.
module tb_result_writeback_mux;

  localparam int NSRC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] d [NSRC];
  logic [63:0] src_data;
  logic [3:0]  src_valid;
  logic [3:0]  src_ready;
  logic        arb_mode;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic [1:0]  out_src;
  logic        out_zero;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  stall_cnt;

  // Three-source instance for the out-of-range select case
  logic [15:0] d3 [3];
  logic [47:0] src_data3;
  logic [2:0]  src_valid3;
  logic [2:0]  src_ready3;
  logic [1:0]  sel3;
  logic [15:0] out_data3;
  logic [1:0]  out_src3;
  logic        out_zero3;
  logic        out_valid3;
  logic [7:0]  stall_cnt3;

  int n_chk = 0;
  int n_fail = 0;

  assign src_data  = {d[3], d[2], d[1], d[0]};
  assign src_data3 = {d3[2], d3[1], d3[0]};

  result_writeback_mux #(.WIDTH(16), .NUM_SRC(4), .SEL_W(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .arb_mode(arb_mode), .sel(sel), .out_data(out_data),
    .out_src(out_src), .out_zero(out_zero), .out_valid(out_valid),
    .out_ready(out_ready), .stall_cnt(stall_cnt)
  );

  result_writeback_mux #(.WIDTH(16), .NUM_SRC(3), .SEL_W(2), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .src_data(src_data3), .src_valid(src_valid3),
    .src_ready(src_ready3), .arb_mode(1'b0), .sel(sel3), .out_data(out_data3),
    .out_src(out_src3), .out_zero(out_zero3), .out_valid(out_valid3),
    .out_ready(1'b1), .stall_cnt(stall_cnt3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic cycn(input int n);
    repeat (n) cyc();
  endtask

  // Behavioural model of the output stage, arbitration pointer and stall counter
  logic        m_ov;
  logic        m_oz;
  logic [15:0] m_od;
  int          m_os;
  int          m_rr;
  int          m_cnt;
  int          m_g;
  int          m_j;
  logic [3:0]  m_rdy;

  task automatic model_reset();
    m_ov  = 1'b0;
    m_oz  = 1'b1;
    m_od  = 16'h0;
    m_os  = 0;
    m_rr  = NSRC - 1;
    m_cnt = 0;
  endtask

  initial model_reset();

  // Compare process: inputs are stable at the falling edge
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    chk("m_out_valid", 32'(out_valid), 32'(m_ov));
    chk("m_out_data",  32'(out_data),  32'(m_od));
    chk("m_out_src",   32'(out_src),   32'(m_os));
    chk("m_out_zero",  32'(out_zero),  32'(m_oz));
    chk("m_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    if (rst_n) begin
      m_g = -1;
      if (!arb_mode) begin
        if (int'(sel) < NSRC && src_valid[sel]) m_g = int'(sel);
      end else begin
        for (int k = 1; k <= NSRC; k++) begin
          m_j = (m_rr + k) % NSRC;
          if (m_g < 0 && src_valid[m_j]) m_g = m_j;
        end
      end
      m_rdy = (m_g >= 0 && (!m_ov || out_ready)) ? (4'b0001 << m_g) : 4'b0000;
      chk("m_src_ready", 32'(src_ready), 32'(m_rdy));
      if (m_ov && !out_ready && m_cnt < 255) m_cnt = m_cnt + 1;
      if (!m_ov || out_ready) begin
        if (m_g >= 0) begin
          m_od = d[m_g];
          m_os = m_g;
          m_oz = (d[m_g] == 16'h0);
          m_ov = 1'b1;
          if (arb_mode) m_rr = m_g;
        end else begin
          m_ov = 1'b0;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NSRC; i++) d[i] = 16'h0;
    for (int i = 0; i < 3; i++) d3[i] = 16'h0;
    src_valid  = 4'b0;
    src_valid3 = 3'b0;
    sel        = 2'd0;
    sel3       = 2'd0;
    arb_mode   = 1'b0;
    out_ready  = 1'b1;

    // Reset state
    cycn(2);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_zero",  32'(out_zero),  32'd1);
    chk("rst_stall",     32'(stall_cnt), 32'd0);
    rst_n = 1'b1;

    // Explicit select
    d[0] = 16'h1234; d[1] = 16'hABCD; src_valid = 4'b0011; sel = 2'd0;
    #1 chk("exp_ready0", 32'(src_ready), 32'h1);
    cyc();
    chk("exp_data0", 32'(out_data), 32'h1234);
    chk("exp_src0",  32'(out_src),  32'd0);
    chk("exp_valid0", 32'(out_valid), 32'd1);
    cyc();
    chk("exp_data0b", 32'(out_data), 32'h1234);
    sel = 2'd1;
    #1 chk("exp_ready1", 32'(src_ready), 32'h2);
    cyc();
    chk("exp_data1", 32'(out_data), 32'hABCD);
    chk("exp_src1",  32'(out_src),  32'd1);

    // Round-robin fairness
    arb_mode = 1'b1; src_valid = 4'b1111;
    for (int i = 0; i < NSRC; i++) d[i] = 16'(i + 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rr_src",   32'(out_src),   32'(i % 4));
      chk("rr_data",  32'(out_data),  32'((i % 4) + 1));
      chk("rr_valid", 32'(out_valid), 32'd1);
    end
    src_valid = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rr_skip_src", 32'(out_src), 32'((i + 2) % 4));
    end

    // Backpressure and counter saturation
    arb_mode = 1'b0; sel = 2'd1; d[1] = 16'hABCD; src_valid = 4'b0010;
    cyc();
    chk("bp_load", 32'(out_data), 32'hABCD);
    out_ready = 1'b0;
    #1 chk("bp_ready0", 32'(src_ready), 32'h0);
    cycn(5);
    chk("bp_data",  32'(out_data),  32'hABCD);
    chk("bp_ready", 32'(src_ready), 32'h0);
    chk("bp_stall5", 32'(stall_cnt), 32'd5);
    cycn(300);
    chk("bp_sat", 32'(stall_cnt), 32'd255);
    cyc();
    chk("bp_sat_hold", 32'(stall_cnt), 32'd255);

    // Selected source not valid: pending word drains, nothing new loads
    src_valid = 4'b0111; sel = 2'd3; out_ready = 1'b1;
    #1 chk("sel3_ready", 32'(src_ready), 32'h0);
    cyc();
    chk("sel3_valid", 32'(out_valid), 32'd0);
    chk("sel3_hold",  32'(out_data),  32'hABCD);

    // Zero data flag
    sel = 2'd2; d[2] = 16'h0000; src_valid = 4'b0100;
    cyc();
    chk("zero_flag", 32'(out_zero), 32'd1);
    chk("zero_src",  32'(out_src),  32'd2);

    // Three-source instance: select 3 is out of range
    d3[2] = 16'h0777; src_valid3 = 3'b111; sel3 = 2'd3;
    #1 chk("n3_ready_oor", 32'(src_ready3), 32'h0);
    cyc();
    chk("n3_valid_oor", 32'(out_valid3), 32'd0);
    sel3 = 2'd2;
    #1 chk("n3_ready2", 32'(src_ready3), 32'h4);
    cyc();
    chk("n3_src2",  32'(out_src3),  32'd2);
    chk("n3_data2", 32'(out_data3), 32'h0777);

    // Mode switch preserves the round-robin pointer
    arb_mode = 1'b1; src_valid = 4'b0100; d[2] = 16'h5555;
    cyc();
    chk("ms_rr2", 32'(out_src), 32'd2);
    arb_mode = 1'b0; sel = 2'd0; src_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ms_exp0", 32'(out_src), 32'd0);
    end
    arb_mode = 1'b1;
    cyc();
    chk("ms_rr3", 32'(out_src), 32'd3);

    // Asynchronous reset between edges while stalled
    out_ready = 1'b0;
    cycn(2);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_stall", 32'(stall_cnt), 32'd0);
    cyc();
    rst_n = 1'b1; arb_mode = 1'b1; src_valid = 4'b1111; out_ready = 1'b1;
    cyc();
    chk("ar_first_rr", 32'(out_src), 32'd0);

    // Random traffic, checked by the model
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NSRC; i++)
        d[i] = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      src_valid = 4'($urandom);
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) arb_mode = ~arb_mode;
      cyc();
    end
    cycn(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
